sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Synthesizable run controller for the pipelined MIPS core; parametrised successor of the fixed-length reset-then-clock bench driver.
- Sequences core reset for a configurable number of cycles, enables the core, and counts cycles and retired instructions.
- Terminates the run on halt, cycle budget exhausted, or (optional) PC hang, and reports a status flag for each.
- Sits between the bench/top level and the core's reset and clock-enable inputs.

Parameters:
- ADDR_W, 32, width of monitored PC.
- CNT_W, 32, width of cycle and retire counters.
- RST_CYCLES, 1, cycles core_rst is held after start; must be ≥1.
- MAX_CYCLES, 250, run-cycle budget; 1 ≤ MAX_CYCLES < 2^CNT_W.
- HANG_LIMIT, 16, consecutive no-progress cycles that declare a hang; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- halt  in  1  core reports halt/sentinel reached.
- retire  in  1  one instruction retired this cycle.
- pc  in  ADDR_W  core fetch PC.
- core_rst  out  1  reset to core, active-high.
- core_en  out  1  core clock enable; equals running.
- running  out  1  high in RUN state.
- done  out  1  run finished; sticky until start or rst.
- timed_out  out  1  finished by budget.
- hung  out  1  finished by hang detect.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- retire_cnt  out  CNT_W  instructions retired in RUN.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- rst, sampled at an edge, forces next cycle to IDLE with: core_rst=1, running=core_en=0, done=timed_out=hung=0, both counters 0, hang counter 0. Applies mid-run too.
- States:
  - IDLE: core_rst=1. start → RESET.
  - RESET: core_rst=1, counters cleared. Held exactly RST_CYCLES cycles via down-counter, then → RUN.
  - RUN: core_rst=0, running=1. start ignored.
  - DONE: core_rst=0, running=0, counters and flags frozen. start → RESET, clearing done, flags and counters on the same edge.
- start latency: start high at edge N → core_rst high for cycles N+1..N+RST_CYCLES (RESET), running=1 from cycle N+RST_CYCLES+1.
- RUN counters:
  - cycle_cnt increments every RUN cycle, including the terminating one.
  - retire_cnt increments when retire=1 and saturates at all-ones.
  - retire is ignored outside RUN.
- Termination, all evaluated on RUN-cycle inputs, transition next edge:
  - halt=1 → DONE, done=1.
  - Otherwise hang condition (optional feature) → DONE, done=1, hung=1.
  - Otherwise cycle_cnt==MAX_CYCLES-1 → DONE, done=1, timed_out=1.
  - Priority: halt > hung > timeout. At most one flag is set.
- Final cycle_cnt equals the number of RUN cycles, so a timeout leaves cycle_cnt=MAX_CYCLES.
- halt outside RUN is ignored.
- Outputs are registered; no combinational input→output paths.

Optional Feature:
- Macro: SIM_RUN_CTRL_HANG_DETECT_EN.
- Defined:
  - Register pc_q captures pc every RUN cycle.
  - Hang counter increments when pc==pc_q and retire=0; any other RUN cycle clears it.
  - When the counter would reach HANG_LIMIT → DONE with hung=1.
  - Counter and pc_q clear in RESET.
- Undefined: no pc_q or hang counter; hung tied 0; pc port present but unused.

Test Plan:
- RST_CYCLES=2, rst, then start pulse at edge 3 → core_rst=1 cycles 4–5, running=1 from cycle 6, cycle_cnt counts 1,2,3…
- Defaults, halt never asserted → after 250 RUN cycles done=1, timed_out=1, hung=0, cycle_cnt=250, running=0.
- halt=1 in RUN cycle where cycle_cnt=40, retire pulsed 30 times before it → done=1, timed_out=0, cycle_cnt=41, retire_cnt=30.
- halt=1 in the same cycle cycle_cnt==249 → done=1, timed_out=0, cycle_cnt=250 (halt priority).
- Macro defined, pc held 0x40 with retire=0 → hung=1 after 16 no-progress cycles. Macro undefined, same stimulus → runs to timed_out=1.
- rst at RUN cycle 100 → next cycle IDLE, core_rst=1, counters 0. Then from DONE, start → flags clear, fresh RESET sequence.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
//   Run controller for the pipelined MIPS core. On start it holds the core in
//   reset for RST_CYCLES cycles, then enables it and counts run cycles and
//   retired instructions until halt, cycle-budget exhaustion or (optionally)
//   a PC hang ends the run. Status flags stay sticky until the next start or rst.
//
//   Optional feature: define SIM_RUN_CTRL_HANG_DETECT_EN to enable PC hang
//   detection. Without it, hung is always 0 and the pc port is unused.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, begins a run from IDLE or DONE
//   halt       in   core reached its halt/sentinel
//   retire     in   one instruction retired this cycle
//   pc         in   core fetch PC (hang detection only)
//   core_rst   out  active-high reset to the core
//   core_en    out  core clock enable (same as running)
//   running    out  high while in RUN
//   done       out  run finished, sticky
//   timed_out  out  run ended by the cycle budget
//   hung       out  run ended by hang detection
//   cycle_cnt  out  RUN cycles elapsed
//   retire_cnt out  instructions retired during RUN (saturating)
//
// Handshake: start and halt are single-cycle level samples, no ready/ack; start
// is only acted on in IDLE or DONE, halt and retire only in RUN.
module sim_run_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 250,
    parameter int HANG_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              retire,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_rst,
    output logic              core_en,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic              hung,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_CNT_INIT = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYCLE   = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              done_q, done_d;
    logic              timed_out_q, timed_out_d;
    logic              hung_q, hung_d;
    logic              hang_trip;

`ifdef SIM_RUN_CTRL_HANG_DETECT_EN
    localparam int HANG_W = $clog2(HANG_LIMIT + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [HANG_W-1:0] hang_cnt_q, hang_cnt_d;
    logic [HANG_W-1:0] hang_next;

    // A cycle with an unchanged PC and no retirement is "no progress"; the
    // run trips on the cycle whose increment would hit HANG_LIMIT.
    always_comb begin
        pc_d       = pc_q;
        hang_cnt_d = hang_cnt_q;
        hang_trip  = 1'b0;
        hang_next  = hang_cnt_q + HANG_W'(1);
        if (state_q == S_RESET) begin
            pc_d       = '0;
            hang_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            pc_d = pc;
            if ((pc == pc_q) && !retire) begin
                hang_cnt_d = hang_next;
                hang_trip  = (hang_next == HANG_W'(HANG_LIMIT));
            end else begin
                hang_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            hang_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            hang_cnt_q <= hang_cnt_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign hang_trip = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        hung_d       = hung_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_CNT_INIT;
                end
            end
            S_RESET: begin
                cycle_cnt_d  = '0;
                retire_cnt_d = '0;
                if (rst_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            S_RUN: begin
                // The terminating cycle is counted too, so a timeout leaves
                // cycle_cnt equal to MAX_CYCLES.
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (retire && (retire_cnt_q != '1)) begin
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                end
                if (halt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (hang_trip) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hung_d  = 1'b1;
                end else if (cycle_cnt_q == LAST_CYCLE) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d      = S_RESET;
                    rst_cnt_d    = RST_CNT_INIT;
                    cycle_cnt_d  = '0;
                    retire_cnt_d = '0;
                    done_d       = 1'b0;
                    timed_out_d  = 1'b0;
                    hung_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            hung_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            hung_q       <= hung_d;
        end
    end

    // All outputs decode registered state only.
    assign core_rst   = (state_q == S_IDLE) || (state_q == S_RESET);
    assign running    = (state_q == S_RUN);
    assign core_en    = (state_q == S_RUN);
    assign done       = done_q;
    assign timed_out  = timed_out_q;
    assign hung       = hung_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl (RST_CYCLES=2, MAX_CYCLES=250, HANG_LIMIT=16).
// Inputs are driven 1 time unit after each rising edge, outputs are checked at
// the same point, well away from the next active edge.
module tb_sim_run_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic              retire = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              core_rst, core_en, running, done, timed_out, hung;
    logic [CNT_W-1:0]  cycle_cnt, retire_cnt;

    int checks = 0;
    int errors = 0;

    sim_run_ctrl #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_CYCLES(2),
        .MAX_CYCLES(250), .HANG_LIMIT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .retire(retire),
        .pc(pc), .core_rst(core_rst), .core_en(core_en), .running(running),
        .done(done), .timed_out(timed_out), .hung(hung),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare status outputs against expected values; used inline by each test.
    task automatic check_status(input string name, input logic e_rst, input logic e_run,
                                input logic e_done, input logic e_to, input logic e_hung,
                                input logic [CNT_W-1:0] e_cyc, input logic [CNT_W-1:0] e_ret);
        checks++;
        if ({core_rst, running, core_en, done, timed_out, hung} !==
                {e_rst, e_run, e_run, e_done, e_to, e_hung} ||
            cycle_cnt !== e_cyc || retire_cnt !== e_ret) begin
            errors++;
            $display("FAIL %s: got rst=%b run=%b en=%b done=%b to=%b hung=%b cyc=%0d ret=%0d, want rst=%b run=%b done=%b to=%b hung=%b cyc=%0d ret=%0d",
                     name, core_rst, running, core_en, done, timed_out, hung, cycle_cnt,
                     retire_cnt, e_rst, e_run, e_done, e_to, e_hung, e_cyc, e_ret);
        end
    endtask

    // Pulse start and walk the two RESET cycles into the first RUN cycle.
    task automatic start_run(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_status({name, "_reset1"}, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_status({name, "_reset2"}, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_status({name, "_run0"}, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_status("reset_state", 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_status("idle_hold", 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start_latency();
        start_run("latency");
        pc = pc + 4;
        tick();
        check_status("latency_cnt1", 0, 1, 0, 0, 0, 1, 0);
        pc = pc + 4;
        tick();
        check_status("latency_cnt2", 0, 1, 0, 0, 0, 2, 0);
    endtask

    // Continues the run from test_start_latency until the budget expires.
    task automatic test_timeout();
        int n;
        n = 2;
        while (!done && n < 400) begin
            pc = pc + 4;
            tick();
            n++;
        end
        checks++;
        if (n !== 250) begin
            errors++;
            $display("FAIL timeout_len: run lasted %0d cycles, want 250", n);
        end
        check_status("timeout_flags", 0, 0, 1, 1, 0, 250, 0);
        start = 1'b0;
        tick();
        check_status("done_frozen", 0, 0, 1, 1, 0, 250, 0);
    endtask

    task automatic test_halt();
        start_run("halt");
        for (int i = 0; i < 40; i++) begin
            retire = (i < 30);
            pc = pc + 4;
            tick();
        end
        retire = 1'b0;
        check_status("halt_pre", 0, 1, 0, 0, 0, 40, 30);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_status("halt_done", 0, 0, 1, 0, 0, 41, 30);
        // retire and halt outside RUN must not change anything
        retire = 1'b1;
        halt = 1'b1;
        tick();
        tick();
        retire = 1'b0;
        halt = 1'b0;
        check_status("halt_frozen", 0, 0, 1, 0, 0, 41, 30);
    endtask

    task automatic test_halt_priority();
        start_run("prio");
        for (int i = 0; i < 249; i++) begin
            pc = pc + 4;
            tick();
        end
        check_status("prio_pre", 0, 1, 0, 0, 0, 249, 0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_status("prio_done", 0, 0, 1, 0, 0, 250, 0);
    endtask

    task automatic test_hang();
        int n;
        pc = 32'h40;
        retire = 1'b0;
        start_run("hang");
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL hang_wait: done=%b after %0d cycles, want 1", done, n);
        end
`ifdef SIM_RUN_CTRL_HANG_DETECT_EN
        // first RUN cycle compares against the cleared pc_q, then 16 stalls
        check_status("hang_flags", 0, 0, 1, 0, 1, 17, 0);
`else
        check_status("hang_off_flags", 0, 0, 1, 1, 0, 250, 0);
`endif
    endtask

    task automatic test_rst_mid_run();
        start_run("midrst");
        for (int i = 0; i < 100; i++) begin
            retire = i[0];
            pc = pc + 4;
            if (i == 60) start = 1'b1;   // start ignored in RUN
            tick();
            start = 1'b0;
        end
        retire = 1'b0;
        check_status("midrst_pre", 0, 1, 0, 0, 0, 100, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status("midrst_idle", 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_status("midrst_idle2", 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        start_run("b2b_a");
        for (int i = 0; i < 5; i++) begin
            retire = 1'b1;
            pc = pc + 4;
            tick();
        end
        retire = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_status("b2b_a_done", 0, 0, 1, 0, 0, 6, 5);
        // restart straight from DONE: flags and counters clear on the start edge
        start_run("b2b_b");
        pc = pc + 4;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_status("b2b_b_done", 0, 0, 1, 0, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_timeout();
        test_halt();
        test_halt_priority();
        test_hang();
        test_rst_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
